// File: rtl/note_arbiter.sv
// Shares the buzzer between keyboard (priority, pre-empts) and song playback; all outputs registered, 1-cycle event latency.
// Define NOTE_ARB_GAP_EN to insert GAP_CYCLES of silence on every note change; otherwise notes switch directly.
module note_arbiter #(
  parameter int GAP_CYCLES  = 2000,
  parameter int KEY_TIMEOUT = 50000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iKey_Valid,
  input  logic [7:0] iKey_Code,
  input  logic       iSong_Enable,
  input  logic [7:0] iSong_Code,
  output logic [7:0] oFreq_Data,
  output logic       oRing,
  output logic [1:0] oSource,
  output logic       oSong_Pause
);

  if (GAP_CYCLES < 1) begin : g_gap_check
    $error("note_arbiter: GAP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SONG,
    S_KEY
`ifdef NOTE_ARB_GAP_EN
    , S_GAP
`endif
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_KEY  = 2'b01;
  localparam logic [1:0] SRC_SONG = 2'b10;

  // Timer holds cycles since the last strobe minus one, so exit happens on the KEY_TIMEOUT-th cycle.
  localparam int TW = (KEY_TIMEOUT > 0) ? $clog2(KEY_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (KEY_TIMEOUT >= 2) ? TW'(KEY_TIMEOUT - 2) : '0;
  localparam logic [TW-1:0] TO_MAX  = '1;

  logic key_on, song_on;
  assign key_on  = iKey_Valid && (iKey_Code != 8'h00);
  assign song_on = iSong_Enable && (iSong_Code != 8'h00);

  state_t        state_q, state_d;
  logic [7:0]    freq_q, freq_d;
  logic          ring_q, ring_d;
  logic [1:0]    src_q, src_d;
  logic          pause_q, pause_d;
  logic [TW-1:0] timer_q, timer_d;

`ifdef NOTE_ARB_GAP_EN
  typedef enum logic [1:0] {P_NONE, P_KEY, P_SONG} pend_t;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [GW-1:0] gap_q, gap_d;
  pend_t         pend_q, pend_d;
  logic [7:0]    pcode_q, pcode_d;
`endif

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    timer_d = timer_q;
`ifdef NOTE_ARB_GAP_EN
    gap_d   = gap_q;
    pend_d  = pend_q;
    pcode_d = pcode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (key_on) begin
          state_d = S_KEY;
          freq_d  = iKey_Code;
          timer_d = '0;
        end else if (song_on) begin
          state_d = S_SONG;
          freq_d  = iSong_Code;
        end
      end
      S_SONG: begin
        if (key_on) begin
`ifdef NOTE_ARB_GAP_EN
          state_d = S_GAP;
          gap_d   = '0;
          pend_d  = P_KEY;
          pcode_d = iKey_Code;
`else
          state_d = S_KEY;
          freq_d  = iKey_Code;
          timer_d = '0;
`endif
        end else if (!song_on) begin
          state_d = S_IDLE;
        end else if (iSong_Code != freq_q) begin
`ifdef NOTE_ARB_GAP_EN
          state_d = S_GAP;
          gap_d   = '0;
          pend_d  = P_SONG;
`else
          freq_d  = iSong_Code;
`endif
        end
      end
      S_KEY: begin
        if (iKey_Valid) begin
          timer_d = '0;
          if (iKey_Code == 8'h00) begin
            state_d = S_IDLE;
          end else if (iKey_Code != freq_q) begin
`ifdef NOTE_ARB_GAP_EN
            state_d = S_GAP;
            gap_d   = '0;
            pend_d  = P_KEY;
            pcode_d = iKey_Code;
`else
            freq_d  = iKey_Code;
`endif
          end
        end else if ((KEY_TIMEOUT != 0) && (timer_q >= TO_LAST)) begin
          state_d = S_IDLE;
        end else if (timer_q != TO_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef NOTE_ARB_GAP_EN
      S_GAP: begin
        // Key events retarget the pending owner without restarting the silence.
        if (key_on) begin
          pend_d  = P_KEY;
          pcode_d = iKey_Code;
        end else if (iKey_Valid) begin
          pend_d  = P_NONE;
        end
        if (gap_q == GAP_LAST) begin
          case (pend_d)
            P_KEY: begin
              state_d = S_KEY;
              freq_d  = pcode_d;
              timer_d = '0;
            end
            P_SONG: begin
              if (song_on) begin
                state_d = S_SONG;
                freq_d  = iSong_Code;
              end else begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) freq_d = '0;
`ifdef NOTE_ARB_GAP_EN
    if (state_d == S_GAP) freq_d = '0;
`endif
    ring_d  = (state_d == S_SONG) || (state_d == S_KEY);
    src_d   = (state_d == S_SONG) ? SRC_SONG : (state_d == S_KEY) ? SRC_KEY : SRC_NONE;
    pause_d = (state_d == S_KEY);
`ifdef NOTE_ARB_GAP_EN
    if ((state_d == S_GAP) && (pend_d == P_KEY)) pause_d = 1'b1;
`endif
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      freq_q  <= '0;
      ring_q  <= 1'b0;
      src_q   <= SRC_NONE;
      pause_q <= 1'b0;
      timer_q <= '0;
`ifdef NOTE_ARB_GAP_EN
      gap_q   <= '0;
      pend_q  <= P_NONE;
      pcode_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      ring_q  <= ring_d;
      src_q   <= src_d;
      pause_q <= pause_d;
      timer_q <= timer_d;
`ifdef NOTE_ARB_GAP_EN
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
`endif
    end
  end

  assign oFreq_Data  = freq_q;
  assign oRing       = ring_q;
  assign oSource     = src_q;
  assign oSong_Pause = pause_q;

endmodule

// File: tb/tb_note_arbiter.sv
// Bench for note_arbiter (GAP_CYCLES=4, KEY_TIMEOUT=20): directed scenarios plus random traffic against an ownership model.
module tb_note_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 20;
`ifdef NOTE_ARB_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [11:0] SILENT = 12'h000;
  localparam logic [11:0] GAPK   = 12'h001;
  localparam logic [11:0] KEY22  = 12'h22B;
  localparam logic [11:0] KEY30  = 12'h30B;
  localparam logic [11:0] S15    = 12'h15C;
  localparam logic [11:0] S17    = 12'h17C;

  logic       clk = 1'b0;
  logic       iReset = 1'b1;
  logic       iKey_Valid = 1'b0;
  logic [7:0] iKey_Code = 8'h00;
  logic       iSong_Enable = 1'b0;
  logic [7:0] iSong_Code = 8'h00;
  logic [7:0] oFreq_Data;
  logic       oRing;
  logic [1:0] oSource;
  logic       oSong_Pause;
  logic [11:0] obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  note_arbiter #(.GAP_CYCLES(GAP), .KEY_TIMEOUT(TO)) dut (
    .iClk(clk), .iReset(iReset), .iKey_Valid(iKey_Valid), .iKey_Code(iKey_Code),
    .iSong_Enable(iSong_Enable), .iSong_Code(iSong_Code), .oFreq_Data(oFreq_Data),
    .oRing(oRing), .oSource(oSource), .oSong_Pause(oSong_Pause)
  );

  assign obs = {oFreq_Data, oRing, oSource, oSong_Pause};

  // Ownership model: who owns the buzzer, how much silence remains, how long since the last key event.
  int         m_owner;   // 0 nobody, 1 song, 2 keyboard, 3 silence
  logic [7:0] m_note = 8'h00;
  logic [7:0] m_next_code = 8'h00;
  int         m_next = 0;     // owner after silence: 0 nobody, 1 keyboard, 2 song
  int         m_silence_left = 0;
  int         m_key_age = 0;

  task automatic own_key(input logic [7:0] c);
    m_owner = 2; m_note = c; m_key_age = 1;
  endtask

  task automatic own_song(input logic [7:0] c);
    m_owner = 1; m_note = c;
  endtask

  task automatic own_none();
    m_owner = 0; m_note = 8'h00;
  endtask

  task automatic change_note(input int nxt, input logic [7:0] c);
    if (GAP_EN) begin
      m_owner = 3; m_note = 8'h00; m_next = nxt; m_next_code = c; m_silence_left = GAP;
    end else if (nxt == 1) own_key(c);
    else own_song(c);
  endtask

  task automatic model_step(input logic rst, input logic kv, input logic [7:0] kc,
                            input logic se, input logic [7:0] sc);
    bit song_ok;
    song_ok = se && (sc != 8'h00);
    if (rst) begin
      own_none(); m_next = 0; m_silence_left = 0; m_key_age = 0;
      return;
    end
    case (m_owner)
      0: if (kv && kc != 8'h00) own_key(kc);
         else if (song_ok) own_song(sc);
      1: if (kv && kc != 8'h00) change_note(1, kc);
         else if (!song_ok) own_none();
         else if (sc != m_note) change_note(2, sc);
      2: if (kv) begin
           if (kc == 8'h00) own_none();
           else if (kc != m_note) change_note(1, kc);
           else m_key_age = 1;
         end else begin
           m_key_age++;
           if (m_key_age >= TO) own_none();
         end
      default: begin
        if (kv) begin
          m_next = (kc != 8'h00) ? 1 : 0;
          if (kc != 8'h00) m_next_code = kc;
        end
        m_silence_left--;
        if (m_silence_left == 0) begin
          if (m_next == 1) own_key(m_next_code);
          else if (m_next == 2 && song_ok) own_song(sc);
          else own_none();
        end
      end
    endcase
  endtask

  function automatic logic [11:0] model_out();
    case (m_owner)
      1: return {m_note, 1'b1, 2'b10, 1'b0};
      2: return {m_note, 1'b1, 2'b01, 1'b1};
      3: return {8'h00, 1'b0, 2'b00, (m_next == 1)};
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic kv, input logic [7:0] kc,
                       input logic se, input logic [7:0] sc);
    @(negedge clk);
    iReset = rst; iKey_Valid = kv; iKey_Code = kc; iSong_Enable = se; iSong_Code = sc;
    @(posedge clk);
    model_step(rst, kv, kc, se, sc);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    n_vec++; if (obs !== SILENT) begin n_err++; $display("FAIL reset_init: got %h want %h", obs, SILENT); end
    drive(1'b0, 1'b1, 8'h30, 1'b0, 8'h00);
    n_vec++; if (obs !== KEY30) begin n_err++; $display("FAIL key_from_idle: got %h want %h", obs, KEY30); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    n_vec++; if (obs !== SILENT) begin n_err++; $display("FAIL reset_in_key: got %h want %h", obs, SILENT); end
  endtask

  task automatic test_song_only();
    logic [11:0] exp;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    n_vec++; if (obs !== S15) begin n_err++; $display("FAIL song_play: got %h want %h", obs, S15); end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h17);
      exp = (GAP_EN && k <= GAP) ? SILENT : S17;
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL song_change k=%0d: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_preempt();
    logic [11:0] exp;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h15);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, k == 1, 8'h22, 1'b1, 8'h15);
      exp = (GAP_EN && k <= GAP) ? GAPK : KEY22;
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL preempt k=%0d: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] exp;
    for (int k = 1; k <= 21; k++) begin
      drive(1'b0, k == 1, 8'h22, 1'b1, 8'h15);
      exp = (k < TO) ? KEY22 : (k == TO) ? SILENT : S15;
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL timeout k=%0d: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h15);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h15);
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, k <= 2, (k == 1) ? 8'h22 : 8'h00, 1'b1, 8'h17);
      if (GAP_EN) exp = (k == 1) ? GAPK : (k <= GAP + 1) ? SILENT : S17;
      else        exp = (k == 1) ? KEY22 : (k == 2) ? SILENT : S17;
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL simultaneous k=%0d: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0] kcodes [4] = '{8'h00, 8'h22, 8'h30, 8'h41};
    logic [7:0] scodes [3] = '{8'h00, 8'h15, 8'h17};
    logic       se = 1'b1;
    logic [7:0] sc = 8'h15;
    logic       kv, rst;
    logic [7:0] kc;
    logic [11:0] exp;
    for (int i = 0; i < 3000; i++) begin
      kv  = ($urandom_range(0, ((i / 400) % 2 == 1) ? 39 : 4) == 0);
      kc  = kcodes[$urandom_range(0, 3)];
      if ($urandom_range(0, 30) == 0) se = ~se;
      if ($urandom_range(0, 15) == 0) sc = scodes[$urandom_range(0, 2)];
      rst = ($urandom_range(0, 599) == 0);
      drive(rst, kv, kc, se, sc);
      exp = model_out();
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL random i=%0d: got %h want %h", i, obs, exp); end
    end
  endtask

  initial begin
    own_none();
    test_reset();
    test_song_only();
    test_preempt();
    test_timeout();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/note_arbiter.md
# note_arbiter

Owns the buzzer datapath (note decoder → ring counter → note player) and shares it between two requesters: live keyboard notes from the PS/2 decoder and playback notes from the selected song module. Keyboard has strict priority and pre-empts playback, which is paused and resumes when the keyboard goes idle. An optional articulation gap silences the buzzer briefly between consecutive notes. Sits between the PS/2 decoder / song selector and the buzzer decoder / counter.

## Interface
- `GAP_CYCLES`, 2000: silent cycles inserted on every note change; must be ≥1.
- `KEY_TIMEOUT`, 50000: idle cycles after the last key event before keyboard ownership lapses; 0 = no timeout.
- `iClk` in 1: system clock.
- `iReset` in 1: synchronous reset, active-high.
- `iKey_Valid` in 1: one-cycle strobe, new keyboard event.
- `iKey_Code` in 8: note code for the event; 0 = key release.
- `iSong_Enable` in 1: a song is selected and playing.
- `iSong_Code` in 8: current song note code (level); 0 = rest.
- `oFreq_Data` out 8: note code to the buzzer decoder.
- `oRing` out 1: buzzer enable to the ring counter.
- `oSource` out 2: 00 none, 01 keyboard, 10 song.
- `oSong_Pause` out 1: freezes song progress while the keyboard owns or is about to own the buzzer.

## Operation
- FSM states: IDLE, SONG, KEY, GAP. GAP holds a pending target: none, KEY with pending code, or SONG.
- IDLE: outputs silent, `oSource`=00.
  - `iKey_Valid` with nonzero code → KEY, latch code.
  - Otherwise `iSong_Enable` and `iSong_Code`≠0 → SONG.
- SONG: `oFreq_Data`=`iSong_Code` as registered, `oRing`=1, `oSource`=10.
  - `iKey_Valid` with nonzero code → GAP (pending KEY, code).
  - `iSong_Code` changes to a different nonzero value → GAP (pending SONG).
  - `iSong_Enable`=0 or `iSong_Code`=0 → IDLE.
- KEY: `oFreq_Data`=latched code, `oRing`=1, `oSource`=01, `oSong_Pause`=1. Timeout counter clears on every `iKey_Valid`.
  - Same code → refresh timer only.
  - Different nonzero code → GAP (pending KEY, new code).
  - Code 0 → IDLE.
  - Counter reaching `KEY_TIMEOUT` → IDLE.
- GAP: `oFreq_Data`=0, `oRing`=0, `oSource`=00. `oSong_Pause`=1 iff pending is KEY. Gap counter runs `GAP_CYCLES` cycles, then enters the pending target.
  - Pending SONG at gap end: if the song is disabled or at rest, go to IDLE instead.
  - Nonzero key event during gap → pending KEY with that code; gap counter is not restarted.
  - Key release during gap → pending none; gap end goes to IDLE.
- Keyboard events always win over song changes in the same cycle.
- Counters are sized `$clog2(param+1)` and saturate; they never wrap.

## Timing
- All outputs are registered.
- Reset: state IDLE, all counters 0, `oFreq_Data`=0, `oRing`=0, `oSource`=00, `oSong_Pause`=0. Reset mid-note or mid-gap yields silence on the next edge, and the pending target is discarded.
- Event latency is 1 cycle: a key strobe at edge n from IDLE gives `oFreq_Data`=code at n+1.
- Pre-emption from SONG: key at n → silent n+1 … n+`GAP_CYCLES` → key note at n+`GAP_CYCLES`+1.
- Timeout: exit to IDLE occurs exactly `KEY_TIMEOUT` cycles after the last key strobe. A song resumes one cycle later via IDLE.
- Song code change takes effect on the next edge, delayed by the gap when the gap is enabled.

## Configuration
- `NOTE_ARB_GAP_EN` defined: GAP state and counter present; behaviour as above.
- `NOTE_ARB_GAP_EN` undefined: no GAP state. Every transition into GAP instead goes directly to its pending target on the same edge, with the code updated, `oRing` held at 1, and `GAP_CYCLES` ignored.

## Test plan
All scenarios use `GAP_CYCLES`=4 and `KEY_TIMEOUT`=20.
- Reset: assert `iReset` while in KEY → next cycle `oFreq_Data`=0, `oRing`=0, `oSource`=00, `oSong_Pause`=0.
- Song only: `iSong_Enable`=1, code 0x15, then 0x17 at n → 0x15 sounds; silent n+1..n+4; 0x17 at n+5.
- Pre-emption: song 0x15 playing, key 0x22 at n → silent n+1..n+4 with `oSong_Pause`=1; 0x22, `oSource`=01 at n+5.
- Timeout/resume: last key strobe at n → KEY through n+19; IDLE at n+20; song note at n+21.
- Simultaneous: key 0x22 and song change in the same cycle from SONG → pending KEY 0x22. Key release during gap → IDLE at gap end.
- Build without `NOTE_ARB_GAP_EN`: repeat the pre-emption scenario → 0x22 at n+1, `oRing` never drops.
